// File: rtl/systolic_pe_os_if.sv
// Bundles the operand, drain and status signals of one output-stationary PE.
// slave is the PE's own view; master is the view of whatever drives it.
interface systolic_pe_os_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16
);
   logic [DATA_W-1:0] a_w;
   logic              a_valid_w;
   logic [DATA_W-1:0] b_n;
   logic              b_valid_n;
   logic              signed_mode;
   logic              acc_clr;
   logic              drain_load;
   logic              drain_shift;
   logic [ACC_W-1:0]  psum_n;
   logic              psum_valid_n;
   logic [DATA_W-1:0] a_e;
   logic              a_valid_e;
   logic [DATA_W-1:0] b_s;
   logic              b_valid_s;
   logic [ACC_W-1:0]  psum_s;
   logic              psum_valid_s;
   logic [CNT_W-1:0]  mac_cnt;
   logic              ovf;

   modport slave (
      input  a_w, a_valid_w, b_n, b_valid_n, signed_mode, acc_clr,
             drain_load, drain_shift, psum_n, psum_valid_n,
      output a_e, a_valid_e, b_s, b_valid_s, psum_s, psum_valid_s,
             mac_cnt, ovf
   );

   modport master (
      output a_w, a_valid_w, b_n, b_valid_n, signed_mode, acc_clr,
             drain_load, drain_shift, psum_n, psum_valid_n,
      input  a_e, a_valid_e, b_s, b_valid_s, psum_s, psum_valid_s,
             mac_cnt, ovf
   );
endinterface

// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: forwards A east and B south, accumulates A*B
// locally with signed/unsigned and saturate/wrap options, and drains results south.
module systolic_pe_os #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 32,
   parameter int SATURATE = 1,
   parameter int CNT_W    = 16
) (
   input logic             clk,
   input logic             rst,
   systolic_pe_os_if.slave bus
);
   localparam int PW = 2 * DATA_W;
   localparam int XW = ACC_W + 1;

   logic [DATA_W-1:0] a_q;
   logic              a_valid_q;
   logic [DATA_W-1:0] b_q;
   logic              b_valid_q;
   logic [ACC_W-1:0]  psum_q;
   logic              psum_valid_q;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              ovf_q;

   logic              mac;
   logic              clear;
   logic [PW-1:0]     a_x;
   logic [PW-1:0]     b_x;
   logic [PW-1:0]     prod;
   logic [XW-1:0]     prod_x;
   logic [XW-1:0]     acc_x;
   logic [XW-1:0]     sum;
   logic              overflow;
   logic [ACC_W-1:0]  sat_val;
   logic [ACC_W-1:0]  acc_mac;

   // Operands are extended to 2*DATA_W before multiplying so the low half of
   // the product is correct for both signed and unsigned interpretation.
   always_comb begin
      mac      = bus.a_valid_w & bus.b_valid_n;
      clear    = bus.acc_clr | bus.drain_load;
      a_x      = {{DATA_W{bus.signed_mode & bus.a_w[DATA_W-1]}}, bus.a_w};
      b_x      = {{DATA_W{bus.signed_mode & bus.b_n[DATA_W-1]}}, bus.b_n};
      prod     = a_x * b_x;
      prod_x   = {{(XW-PW){bus.signed_mode & prod[PW-1]}}, prod};
      acc_x    = {bus.signed_mode & acc[ACC_W-1], acc};
      sum      = acc_x + prod_x;
      overflow = bus.signed_mode ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
      sat_val  = '1;
      if (bus.signed_mode) begin
         sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
      acc_mac = sum[ACC_W-1:0];
      if (overflow && (SATURATE != 0)) begin
         acc_mac = sat_val;
      end
   end

   // A drain_load clears the tile exactly like acc_clr, after psum_s has
   // captured the pre-update accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q          <= '0;
         a_valid_q    <= 1'b0;
         b_q          <= '0;
         b_valid_q    <= 1'b0;
         psum_q       <= '0;
         psum_valid_q <= 1'b0;
         acc          <= '0;
         cnt          <= '0;
         ovf_q        <= 1'b0;
      end else begin
         a_q       <= bus.a_w;
         a_valid_q <= bus.a_valid_w;
         b_q       <= bus.b_n;
         b_valid_q <= bus.b_valid_n;

         if (bus.drain_load) begin
            psum_q       <= acc;
            psum_valid_q <= 1'b1;
         end else if (bus.drain_shift) begin
            psum_q       <= bus.psum_n;
            psum_valid_q <= bus.psum_valid_n;
         end else begin
            psum_valid_q <= 1'b0;
         end

         if (clear) begin
            acc   <= mac ? prod_x[ACC_W-1:0] : '0;
            cnt   <= CNT_W'(mac);
            ovf_q <= 1'b0;
         end else if (mac) begin
            acc <= acc_mac;
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
            if (overflow) begin
               ovf_q <= 1'b1;
            end
         end
      end
   end

   assign bus.a_e          = a_q;
   assign bus.a_valid_e    = a_valid_q;
   assign bus.b_s          = b_q;
   assign bus.b_valid_s    = b_valid_q;
   assign bus.psum_s       = psum_q;
   assign bus.psum_valid_s = psum_valid_q;
   assign bus.mac_cnt      = cnt;
   assign bus.ovf          = ovf_q;
endmodule

// File: tb/tb_systolic_pe_os.sv
// Directed bench for systolic_pe_os: a default PE, two 16-bit PEs (saturating
// and wrapping) sharing its stimulus, and a 4-PE drain column.
module tb_systolic_pe_os;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  a, b;
   logic        av, bv, sm, clr, load, shift, pnv;
   logic [31:0] pn;
   logic [7:0]  col_a [4];
   logic        col_v, col_clr, col_load, col_shift;
   int          nAsserts = 0;
   int          nFails   = 0;

   always #5 clk = ~clk;

   systolic_pe_os_if #(.DATA_W(8), .ACC_W(32), .CNT_W(16)) m_if ();
   systolic_pe_os_if #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) s_if ();
   systolic_pe_os_if #(.DATA_W(8), .ACC_W(16), .CNT_W(16)) w_if ();
   systolic_pe_os_if #(.DATA_W(8), .ACC_W(32), .CNT_W(16)) col_if [4] ();

   assign m_if.a_w = a;           assign s_if.a_w = a;           assign w_if.a_w = a;
   assign m_if.a_valid_w = av;    assign s_if.a_valid_w = av;    assign w_if.a_valid_w = av;
   assign m_if.b_n = b;           assign s_if.b_n = b;           assign w_if.b_n = b;
   assign m_if.b_valid_n = bv;    assign s_if.b_valid_n = bv;    assign w_if.b_valid_n = bv;
   assign m_if.signed_mode = sm;  assign s_if.signed_mode = sm;  assign w_if.signed_mode = sm;
   assign m_if.acc_clr = clr;     assign s_if.acc_clr = clr;     assign w_if.acc_clr = clr;
   assign m_if.drain_load = load; assign s_if.drain_load = load; assign w_if.drain_load = load;
   assign m_if.drain_shift = shift; assign s_if.drain_shift = shift; assign w_if.drain_shift = shift;
   assign m_if.psum_n = pn;       assign s_if.psum_n = pn[15:0]; assign w_if.psum_n = pn[15:0];
   assign m_if.psum_valid_n = pnv; assign s_if.psum_valid_n = pnv; assign w_if.psum_valid_n = pnv;

   systolic_pe_os #(.DATA_W(8), .ACC_W(32), .SATURATE(1), .CNT_W(16)) u_main (.clk(clk), .rst(rst), .bus(m_if));
   systolic_pe_os #(.DATA_W(8), .ACC_W(16), .SATURATE(1), .CNT_W(16)) u_sat  (.clk(clk), .rst(rst), .bus(s_if));
   systolic_pe_os #(.DATA_W(8), .ACC_W(16), .SATURATE(0), .CNT_W(16)) u_wrap (.clk(clk), .rst(rst), .bus(w_if));

   // Column: each PE loads its own A value times 1, then results drain southward.
   for (genvar g = 0; g < 4; g++) begin : g_col
      assign col_if[g].a_w         = col_a[g];
      assign col_if[g].a_valid_w   = col_v;
      assign col_if[g].b_n         = 8'd1;
      assign col_if[g].b_valid_n   = col_v;
      assign col_if[g].signed_mode = 1'b0;
      assign col_if[g].acc_clr     = col_clr;
      assign col_if[g].drain_load  = col_load;
      assign col_if[g].drain_shift = col_shift;
      if (g == 0) begin : g_top
         assign col_if[g].psum_n       = '0;
         assign col_if[g].psum_valid_n = 1'b0;
      end else begin : g_link
         assign col_if[g].psum_n       = col_if[g-1].psum_s;
         assign col_if[g].psum_valid_n = col_if[g-1].psum_valid_s;
      end
      systolic_pe_os #(.DATA_W(8), .ACC_W(32), .SATURATE(1), .CNT_W(16)) u_pe (
         .clk(clk), .rst(rst), .bus(col_if[g]));
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the shared PE inputs for one cycle.
   task automatic applyStimulus(input logic [7:0] ia, input logic iav, input logic [7:0] ib,
                                input logic ibv, input logic ism, input logic iclr,
                                input logic iload, input logic ishift);
      a = ia; av = iav; b = ib; bv = ibv; sm = ism; clr = iclr; load = iload; shift = ishift;
      tick();
   endtask

   // One counted comparison.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      pn = '0; pnv = 1'b0;
      col_a[0] = 8'd0; col_a[1] = 8'd0; col_a[2] = 8'd0; col_a[3] = 8'd0;
      col_v = 1'b0; col_clr = 1'b0; col_load = 1'b0; col_shift = 1'b0;

      // Reset held with random inputs
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pn  = $urandom;
         pnv = 1'b1;
         applyStimulus(8'($urandom), 1'b1, 8'($urandom), 1'b1, 1'($urandom), 1'($urandom),
                       1'($urandom), 1'b1);
         checkOutput("rst_a_e", 32'(m_if.a_e), 32'd0);
         checkOutput("rst_psum_valid", 32'(m_if.psum_valid_s), 32'd0);
      end
      checkOutput("rst_a_valid_e", 32'(m_if.a_valid_e), 32'd0);
      checkOutput("rst_b_s", 32'(m_if.b_s), 32'd0);
      checkOutput("rst_b_valid_s", 32'(m_if.b_valid_s), 32'd0);
      checkOutput("rst_psum_s", m_if.psum_s, 32'd0);
      checkOutput("rst_mac_cnt", 32'(m_if.mac_cnt), 32'd0);
      checkOutput("rst_ovf", 32'(m_if.ovf), 32'd0);
      pn = '0; pnv = 1'b0;
      rst = 1'b0;
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("post_rst_mac_cnt", 32'(m_if.mac_cnt), 32'd0);

      // Signed MAC: 16384 - 127 + 12 = 16269
      applyStimulus(8'h80, 1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'd127, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'd3, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("s_mac_cnt", 32'(m_if.mac_cnt), 32'd3);
      checkOutput("s_a_e", 32'(m_if.a_e), 32'd3);
      checkOutput("s_b_s", 32'(m_if.b_s), 32'd4);
      checkOutput("s_a_valid_e", 32'(m_if.a_valid_e), 32'd1);
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("s_psum", m_if.psum_s, 32'd16269);
      checkOutput("s_psum_valid", 32'(m_if.psum_valid_s), 32'd1);
      checkOutput("s_cnt_after_load", 32'(m_if.mac_cnt), 32'd0);
      applyStimulus(8'h5A, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("idle_psum_valid", 32'(m_if.psum_valid_s), 32'd0);
      checkOutput("idle_psum_hold", m_if.psum_s, 32'd16269);
      checkOutput("fwd_invalid_a", 32'(m_if.a_e), 32'h5A);
      checkOutput("fwd_invalid_b", 32'(m_if.b_s), 32'hA5);
      checkOutput("fwd_invalid_av", 32'(m_if.a_valid_e), 32'd0);

      // Unsigned 255*255 x4 = 260100; 16-bit: saturates to FFFF, wraps to F804
      applyStimulus(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("u_sat_ovf", 32'(s_if.ovf), 32'd1);
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("u_psum", m_if.psum_s, 32'd260100);
      checkOutput("u_sat_psum", 32'(s_if.psum_s), 32'h0000FFFF);
      checkOutput("u_wrap_psum", 32'(w_if.psum_s), 32'h0000F804);
      // Same bits signed: -1*-1 x4 = 4
      applyStimulus(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("neg1_psum", m_if.psum_s, 32'd4);
      checkOutput("neg1_sat_psum", 32'(s_if.psum_s), 32'd4);

      // Signed 127*127 x3 = 48387: clamps to 7FFF, wraps to BD03 in 16 bits
      applyStimulus(8'd127, 1'b1, 8'd127, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'd127, 1'b1, 8'd127, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'd127, 1'b1, 8'd127, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("sat_ovf", 32'(s_if.ovf), 32'd1);
      checkOutput("wrap_ovf", 32'(w_if.ovf), 32'd1);
      checkOutput("wide_no_ovf", 32'(m_if.ovf), 32'd0);
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("sat_psum", 32'(s_if.psum_s), 32'h00007FFF);
      checkOutput("wrap_psum", 32'(w_if.psum_s), 32'h0000BD03);
      checkOutput("wide_psum", m_if.psum_s, 32'd48387);
      checkOutput("ovf_clr_by_load", 32'(s_if.ovf), 32'd0);

      // Corner cases
      applyStimulus(8'd7, 1'b1, 8'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'd5, 1'b1, 8'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("clr_mac_psum", m_if.psum_s, 32'd63);
      checkOutput("load_mac_cnt", 32'(m_if.mac_cnt), 32'd1);
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("load_mac_acc", m_if.psum_s, 32'd30);
      checkOutput("load_cnt_zero", 32'(m_if.mac_cnt), 32'd0);
      pn = 32'hDEADBEEF; pnv = 1'b0;
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("shift_psum", m_if.psum_s, 32'hDEADBEEF);
      checkOutput("shift_valid", 32'(m_if.psum_valid_s), 32'd0);
      applyStimulus(8'd2, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      pn = 32'd99; pnv = 1'b1;
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("load_beats_shift", m_if.psum_s, 32'd6);
      checkOutput("load_beats_shift_v", 32'(m_if.psum_valid_s), 32'd1);
      rst = 1'b1;
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_mid_drain_v", 32'(m_if.psum_valid_s), 32'd0);
      checkOutput("rst_mid_drain_p", m_if.psum_s, 32'd0);
      rst = 1'b0; pn = '0; pnv = 1'b0;
      applyStimulus(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Drain column: 10,20,30,40 top->bottom, bottom sees 40,30,20,10
      col_a[0] = 8'd10; col_a[1] = 8'd20; col_a[2] = 8'd30; col_a[3] = 8'd40;
      col_v = 1'b1; col_clr = 1'b1;
      tick();
      col_v = 1'b0; col_clr = 1'b0; col_load = 1'b1;
      tick();
      checkOutput("col_load_psum", col_if[3].psum_s, 32'd40);
      checkOutput("col_load_valid", 32'(col_if[3].psum_valid_s), 32'd1);
      col_load = 1'b0; col_shift = 1'b1;
      tick();
      checkOutput("col_shift1", col_if[3].psum_s, 32'd30);
      checkOutput("col_shift1_v", 32'(col_if[3].psum_valid_s), 32'd1);
      tick();
      checkOutput("col_shift2", col_if[3].psum_s, 32'd20);
      tick();
      checkOutput("col_shift3", col_if[3].psum_s, 32'd10);
      checkOutput("col_shift3_v", 32'(col_if[3].psum_valid_s), 32'd1);
      col_shift = 1'b0;
      tick();
      checkOutput("col_idle_v", 32'(col_if[3].psum_valid_s), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end
endmodule
